// File: rtl/mux_stream_rr_if.sv
// rtl/mux_stream_rr_if.sv - channel, select and output stream bundle for mux_stream_rr
interface mux_stream_rr_if #(
   parameter int WIDTH  = 128,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_valid;
   logic                    out_ready;
   logic [CNT_W-1:0]        xfer_count;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid, xfer_count
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid, xfer_count
   );
endinterface

// File: rtl/mux_stream_rr.sv
// rtl/mux_stream_rr.sv - NUM_CH:1 stream selector, direct or round-robin grant, registered output
module mux_stream_rr #(
   parameter int WIDTH  = 128,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic           clk,
   input  logic           reset,
   mux_stream_rr_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [WIDTH-1:0] ch_data [NUM_CH];
   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_ch_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] xfer_count_q;
   logic [SEL_W-1:0] ptr;

   logic             load_en;
   logic             dir_valid;
   logic             rr_valid;
   logic [SEL_W-1:0] rr_idx;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic             transfer;
   int               rr_pos;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
   end

   assign load_en = !out_valid_q || bus.out_ready;

   // Out-of-range select codes (non power-of-two NUM_CH) must never grant.
   assign dir_valid = (int'(bus.sel) < NUM_CH) && bus.in_valid[bus.sel];

   always_comb begin
      rr_valid = 1'b0;
      rr_idx   = '0;
      rr_pos   = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         rr_pos = (int'(ptr) + i) % NUM_CH;
         if (!rr_valid && bus.in_valid[SEL_W'(rr_pos)]) begin
            rr_valid = 1'b1;
            rr_idx   = SEL_W'(rr_pos);
         end
      end
   end

   assign grant       = bus.mode ? rr_idx : bus.sel;
   assign grant_valid = !reset && (bus.mode ? rr_valid : dir_valid);
   assign transfer    = grant_valid && load_en;
   assign bus.in_ready = transfer ? (NUM_CH'(1) << grant) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q   <= '0;
         out_ch_q     <= '0;
         out_valid_q  <= 1'b0;
         ptr          <= SEL_W'(NUM_CH - 1);
         xfer_count_q <= '0;
      end else begin
         if (out_valid_q && bus.out_ready)
            xfer_count_q <= xfer_count_q + CNT_W'(1);
         if (transfer) begin
            out_data_q  <= ch_data[grant];
            out_ch_q    <= grant;
            out_valid_q <= 1'b1;
            ptr         <= grant;
         end else if (load_en) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_data   = out_data_q;
   assign bus.out_ch     = out_ch_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.xfer_count = xfer_count_q;
endmodule

// File: tb/tb_mux_stream_rr.sv
// tb/tb_mux_stream_rr.sv - directed and randomized checks of mux_stream_rr against a reference model
module tb_mux_stream_rr;
   localparam int W  = 128;
   localparam int N  = 4;
   localparam int CW = 4;
   localparam int W3 = 16;
   localparam int N3 = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mux_stream_rr_if #(.WIDTH(W),  .NUM_CH(N),  .CNT_W(CW)) a_if ();
   mux_stream_rr_if #(.WIDTH(W3), .NUM_CH(N3), .CNT_W(32)) b_if ();

   mux_stream_rr #(.WIDTH(W),  .NUM_CH(N),  .CNT_W(CW)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
   mux_stream_rr #(.WIDTH(W3), .NUM_CH(N3), .CNT_W(32)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

   int n_cmp = 0;
   int n_bad = 0;
   int seq   = 0;

   logic [W-1:0] ch_data [N];

   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_ch;
   int           m_last;
   int           m_cnt;

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_last  = N - 1;
      m_cnt   = 0;
   endtask

   // Round-robin winner: the valid channel at the smallest forward distance past the last grant.
   function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v, input int last);
      int best;
      int bd;
      int d;
      best = -1;
      bd   = N + 1;
      if (!md) return (s < N && v[s]) ? s : -1;
      for (int k = 0; k < N; k++) begin
         d = (k - last - 1 + 2*N) % N;
         if (v[k] && d < bd) begin
            bd   = d;
            best = k;
         end
      end
      return best;
   endfunction

   task automatic pack_a();
      for (int k = 0; k < N; k++) a_if.in_data[k*W +: W] = ch_data[k];
   endtask

   task automatic step_a(output int acc);
      int           g;
      logic [N-1:0] rdy;
      bit           load;
      #1;
      load = !m_valid || a_if.out_ready;
      g    = model_grant(a_if.mode, int'(a_if.sel), a_if.in_valid, m_last);
      rdy  = '0;
      acc  = -1;
      if (g >= 0 && load) begin
         rdy[g] = 1'b1;
         acc    = g;
      end
      check_eq("in_ready", W'(a_if.in_ready), W'(rdy));
      if (m_valid && a_if.out_ready) m_cnt = (m_cnt + 1) % (1 << CW);
      if (load) begin
         if (acc >= 0) begin
            m_valid = 1'b1;
            m_data  = ch_data[acc];
            m_ch    = acc;
            m_last  = acc;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check_eq("out_valid",  W'(a_if.out_valid),  W'(m_valid));
      check_eq("out_data",   a_if.out_data,       m_data);
      check_eq("out_ch",     W'(a_if.out_ch),     W'(m_ch));
      check_eq("xfer_count", W'(a_if.xfer_count), W'(m_cnt));
   endtask

   task automatic drive_rand(input int acc);
      for (int k = 0; k < N; k++) begin
         if (k == acc || !a_if.in_valid[k]) begin
            a_if.in_valid[k] = ($urandom_range(0, 2) != 0);
            seq++;
            ch_data[k] = {8'(k), 24'(seq), $urandom, $urandom, $urandom};
         end
      end
      pack_a();
      if ($urandom_range(0, 15) == 0) a_if.mode = ~a_if.mode;
      a_if.sel       = 2'($urandom_range(0, 3));
      a_if.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      int acc;
      int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

      a_if.mode = 1'b0; a_if.sel = '0; a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = 1'b0;
      for (int k = 0; k < N; k++) ch_data[k] = '0;
      b_if.mode = 1'b0; b_if.sel = 2'd3; b_if.in_valid = 3'b111;
      b_if.in_data = {16'h3333, 16'h2222, 16'h1111}; b_if.out_ready = 1'b1;
      model_reset();
      acc = -1;

      #12;
      check_eq("rst_out_valid", W'(a_if.out_valid),  '0);
      check_eq("rst_xfer",      W'(a_if.xfer_count), '0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_eq("oor_ready", W'(b_if.in_ready),  '0);
         check_eq("oor_valid", W'(b_if.out_valid), '0);
      end
      b_if.sel = 2'd1;
      #1;
      check_eq("b_dir_ready", W'(b_if.in_ready), W'(3'b010));
      @(posedge clk);
      #1;
      check_eq("b_dir_data", W'(b_if.out_data), W'(16'h2222));
      check_eq("b_dir_ch",   W'(b_if.out_ch),   W'(1));
      b_if.in_valid = '0;

      a_if.mode = 1'b1; a_if.in_valid = 4'hF; a_if.out_ready = 1'b1;
      for (int k = 0; k < N; k++) ch_data[k] = W'(k);
      pack_a();
      for (int i = 0; i < 7; i++) begin
         step_a(acc);
         if (i < 6) check_eq("rr_ch", W'(a_if.out_ch), W'(rr_seq[i]));
      end
      check_eq("rr_count", W'(a_if.xfer_count), W'(6));

      a_if.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step_a(acc);
         check_eq("bp_ch",    W'(a_if.out_ch),     W'(2));
         check_eq("bp_data",  a_if.out_data,       W'(2));
         check_eq("bp_cnt",   W'(a_if.xfer_count), W'(6));
      end
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step_a(acc);

      a_if.mode = 1'b0; a_if.sel = 2'd2; a_if.in_valid = 4'b0100;
      ch_data[2] = {16{8'hA5}};
      pack_a();
      #1;
      check_eq("dir_ready", W'(a_if.in_ready), W'(4'b0100));
      step_a(acc);
      check_eq("dir_data", a_if.out_data,   {16{8'hA5}});
      check_eq("dir_ch",   W'(a_if.out_ch), W'(2));

      a_if.sel = 2'd1; a_if.in_valid = 4'b0010;
      step_a(acc);
      a_if.mode = 1'b1; a_if.in_valid = 4'hF;
      step_a(acc);
      check_eq("toggle_ch", W'(a_if.out_ch), W'(2));

      for (int i = 0; i < 3000; i++) begin
         drive_rand(acc);
         step_a(acc);
      end

      a_if.mode = 1'b1; a_if.in_valid = 4'hF; a_if.out_ready = 1'b1;
      pack_a();
      step_a(acc);
      step_a(acc);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_out_valid", W'(a_if.out_valid),  '0);
      check_eq("arst_out_data",  a_if.out_data,       '0);
      check_eq("arst_xfer",      W'(a_if.xfer_count), '0);
      check_eq("arst_in_ready",  W'(a_if.in_ready),   '0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step_a(acc);
      check_eq("post_rst_ch", W'(a_if.out_ch), W'(0));
      for (int i = 0; i < 16; i++) step_a(acc);
      check_eq("wrap_cnt", W'(a_if.xfer_count), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Parametrised successor of the 128-bit 4:1 datapath selector. It takes NUM_CH streamed channels of WIDTH bits and delivers one channel per cycle to a single registered output. Every input and the output use a valid/ready handshake. Channel choice is either direct, from a select input, or round-robin among requesting channels. It sits between the multiplier partial-result sources and the result writeback stage, where the old selector sat, and adds backpressure and fair arbitration.

## Interface
- WIDTH, 128, data width per channel.
- NUM_CH, 4, number of input channels; legal range is 2..16.
- SEL_W, $clog2(NUM_CH), width of the select and channel-ID signals; derived, not overridden.
- CNT_W, 32, width of the transfer counter.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; asserting it clears all state immediately.
- mode  in  1  arbitration mode: 0 = direct select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_data  in  NUM_CH*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; one-hot or all zero.
- out_data  out  WIDTH  registered output data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- xfer_count  out  CNT_W  count of completed output handshakes.

## Operation
- The output stage is a single register holding out_data, out_ch and out_valid.
- load_en = !out_valid || out_ready.
- Grant, direct mode (mode=0):
  - grant = sel when sel < NUM_CH and in_valid[sel]=1.
  - Otherwise there is no grant. An out-of-range sel never selects anything and never produces data.
- Grant, round-robin mode (mode=1):
  - Search starts at ptr+1 (mod NUM_CH) and proceeds in ascending index order.
  - The first channel with in_valid=1 wins.
  - If no channel is valid, there is no grant.
- in_ready[grant] = load_en; all other in_ready bits are 0. in_ready is combinational from out_ready, mode, sel, in_valid and ptr.
- Input transfer happens when in_valid[k] && in_ready[k]. On the next edge:
  - out_data <= channel k data;
  - out_ch <= k;
  - out_valid <= 1.
- Drain: when load_en=1 and there is no grant, out_valid <= 0 on the next edge. out_data and out_ch hold their last values.
- Stall: when out_valid=1 and out_ready=0:
  - out_data, out_ch and out_valid hold;
  - all in_ready bits are 0.
- ptr register:
  - Updated to k on every input transfer, in either mode. Mode switches therefore keep fairness history.
  - Reset value is NUM_CH-1, so channel 0 has first priority after reset.
- xfer_count increments by 1 on each edge with out_valid && out_ready. It wraps from 2^CNT_W-1 to 0 with no flag.
- mode and sel may change on any cycle. A change affects only the next grant; a value already in the output register is never replaced or dropped.
- Upstream contract: a channel holding in_valid must keep its data stable until accepted. The block does not check this.

## Timing
- Reset values, applied asynchronously on assertion:
  - out_valid = 0, out_data = 0, out_ch = 0;
  - ptr = NUM_CH-1, xfer_count = 0.
  - in_ready = 0 while reset is high.
- Latency: 1 cycle. Data accepted at edge N is visible on out_data with out_valid=1 after edge N.
- Throughput: 1 transfer per cycle while out_ready=1 and a grant exists. There are no bubbles on back-to-back transfers.
- Simultaneous output handshake and new input transfer on the same edge: the register loads the new data, out_valid stays 1, and xfer_count increments.
- Reset asserted mid-transfer: the held output word is discarded. out_valid drops without waiting for a clock edge. The first grant after release follows the reset pointer.
- Reset deassertion is synchronised externally; the block needs no recovery cycles.

## Test plan
- Reset: drive all inputs valid, then assert reset mid-stream. Required: out_valid=0, out_data=0, xfer_count=0 immediately, with no clock edge needed; after release in mode=1, channel 0 is granted first.
- Direct select (NUM_CH=4, mode=0, sel=2): channel 2 data 128'hA5..A5 with in_valid=4'b0100, out_ready=1. Required: in_ready=4'b0100; the next cycle shows out_data=A5..A5, out_ch=2, out_valid=1.
- Out-of-range select (NUM_CH=3, sel=3, all valid): required in_ready=0 and out_valid stays 0 for 10 cycles.
- Round-robin fairness (mode=1, all four valid, out_ready=1, channel k data = k). Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles; after 6 handshakes xfer_count=6.
- Backpressure (out_ready=0 for 5 cycles with the output full). Required: out_data and out_ch are stable, in_ready=0 and xfer_count is unchanged. On release, one transfer per cycle resumes with no data lost or duplicated, checked against a scoreboard.
- Counter wrap (CNT_W=4): after 16 handshakes xfer_count=0. A mode toggle mid-stream resumes from the stored ptr, e.g. after last grant 1, mode=1 grants channel 2 next.
